// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - op_e    : operation encodings driven on the unit's `op` port
//   - state_e : control FSM states (IDLE -> RUN -> FIX -> IDLE)
//   - cnt_width() : iteration counter width for a given operand width
// -----------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    // The counter must be able to hold DATA_W itself, hence the +1.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage : mdu_pkg

// File: rtl/mdu_iter_core.sv
// -----------------------------------------------------------------------------
// mdu_iter_core
// Shared 2*DATA_W shift register plus the one-bit-per-cycle add/subtract step
// used for both unsigned multiply (shift-add) and unsigned divide (restoring
// shift-subtract). Operands arrive already reduced to magnitudes.
//
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   load_i         : load a_i into the low half, clear the high half, latch b_i
//   step_i         : perform one iteration
//   div_mode_i     : 0 = multiply step, 1 = divide step
//   a_i, b_i       : multiplicand/dividend and multiplier/divisor magnitudes
//   acc_o          : accumulator; after DATA_W steps holds the product, or
//                    {remainder, quotient} for a divide
// -----------------------------------------------------------------------------
module mdu_iter_core #(
    parameter int DATA_W = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic                  div_mode_i,
    input  logic [DATA_W-1:0]     a_i,
    input  logic [DATA_W-1:0]     b_i,
    output logic [2*DATA_W-1:0]   acc_o
);

    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W:0]     add_sum;   // high half + multiplier, with carry
    logic [DATA_W:0]     rem_sh;    // partial remainder after the left shift
    logic [DATA_W:0]     diff;      // trial subtraction; MSB set means borrow

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        acc_d   = acc_q;
        b_d     = b_q;
        add_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, b_q} : '0);
        rem_sh  = acc_q[2*DATA_W-1:DATA_W-1];
        diff    = rem_sh - {1'b0, b_q};

        if (load_i) begin
            acc_d = {{DATA_W{1'b0}}, a_i};
            b_d   = b_i;
        end else if (step_i) begin
            if (div_mode_i) begin
                // Partial remainder is always < 2*b, so a clear borrow bit
                // means it fits back into DATA_W bits and a quotient 1 is due.
                if (!diff[DATA_W]) begin
                    acc_d = {diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*DATA_W-2:0], 1'b0};
                end
            end else begin
                // Multiplier bits are consumed from the LSB while the product
                // grows in from the top, carry included.
                acc_d = {add_sum, acc_q[DATA_W-1:1]};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
        end
    end

    assign acc_o = acc_q;

endmodule : mdu_iter_core

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Issue-to-result latency is DATA_W+1 cycles: one cycle per bit in RUN, then
// one FIX cycle that applies signs and writes HI/LO while pulsing `done`.
//
// Parameters:
//   DATA_W   : operand/HI/LO width, legal range 8..64
// Ports:
//   clock, reset_n      : clock and asynchronous active-low reset
//   start, op           : issue request (sampled only in IDLE) and operation
//   src_a, src_b        : multiplicand/dividend and multiplier/divisor
//   hi_we, lo_we, wdata : MTHI/MTLO write path, honoured only in IDLE
//   busy                : operation in flight
//   done                : one-cycle pulse, HI/LO hold the new result
//   hi, lo              : HI and LO registers
//   div0                : only with MDU_DIV0_FLAG_EN defined; high with `done`
//                         when a DIV/DIVU had a zero divisor
//
// Optional feature macro: MDU_DIV0_FLAG_EN
// -----------------------------------------------------------------------------
module mul_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              hi_we,
    input  logic              lo_we,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
`ifdef MDU_DIV0_FLAG_EN
    ,
    output logic              div0
`endif
);

    import mdu_pkg::*;

    localparam int              CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_div_q, is_div_d;
    logic                neg_lo_q, neg_lo_d;   // product sign, or quotient sign
    logic                neg_hi_q, neg_hi_d;   // remainder sign (divide only)
    logic                b_zero_q, b_zero_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
`ifdef MDU_DIV0_FLAG_EN
    logic                div0_q, div0_d;
`endif

    op_e                 op_in;
    logic                op_signed, op_div;
    logic                a_neg, b_neg;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic                core_load, core_step;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] mul_res;
    logic [DATA_W-1:0]   quo_res, rem_res;

    // Operand conditioning: signed ops work on magnitudes. The magnitude of
    // MIN wraps to MIN itself, which is still the correct unsigned magnitude.
    assign op_in     = op_e'(op);
    assign op_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign op_div    = (op_in == OP_DIV)  || (op_in == OP_DIVU);
    assign a_neg     = op_signed & src_a[DATA_W-1];
    assign b_neg     = op_signed & src_b[DATA_W-1];
    assign a_mag     = a_neg ? -src_a : src_a;
    assign b_mag     = b_neg ? -src_b : src_b;

    mdu_iter_core #(
        .DATA_W     (DATA_W)
    ) u_core (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (core_load),
        .step_i     (core_step),
        .div_mode_i (is_div_q),
        .a_i        (a_mag),
        .b_i        (b_mag),
        .acc_o      (acc)
    );

    // Sign fix-up. A zero divisor leaves the raw all-ones quotient alone; the
    // remainder then equals |a| and re-applying sign(a) restores src_a.
    assign mul_res = neg_lo_q ? -acc : acc;
    assign quo_res = b_zero_q ? '1 : (neg_lo_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0]);
    assign rem_res = neg_hi_q ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        b_zero_d  = b_zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        core_load = 1'b0;
        core_step = 1'b0;
`ifdef MDU_DIV0_FLAG_EN
        div0_d    = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // start takes priority; a simultaneous MTHI/MTLO is dropped
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    core_load = 1'b1;
                    is_div_d  = op_div;
                    neg_lo_d  = a_neg ^ b_neg;
                    neg_hi_d  = a_neg;
                    b_zero_d  = (src_b == '0);
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_RUN: begin
                core_step = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (is_div_q) begin
                    hi_d = rem_res;
                    lo_d = quo_res;
                end else begin
                    hi_d = mul_res[2*DATA_W-1:DATA_W];
                    lo_d = mul_res[DATA_W-1:0];
                end
`ifdef MDU_DIV0_FLAG_EN
                div0_d = is_div_q & b_zero_q;
`endif
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            b_zero_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
            div0_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            b_zero_q <= b_zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MDU_DIV0_FLAG_EN
            div0_q   <= div0_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MDU_DIV0_FLAG_EN
    assign div0 = div0_q;
`endif

endmodule : mul_div_unit
